// File: rtl/sdram_p0_line_reader_if.sv
// Port-0 request/response bus and 16-bit output stream
// bundled for the SDRAM line reader.
interface sdram_p0_line_reader_if #(
  parameter int ADDR_WIDTH = 25
);
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic                  p0_rd_req;
  logic [1:0]            p0_byte_en;
  logic                  p0_ready;
  logic                  p0_available;
  logic [127:0]          p0_q;
  logic [15:0]           out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output p0_addr, p0_rd_req, p0_byte_en,
    input  p0_ready, p0_available, p0_q,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  p0_addr, p0_rd_req, p0_byte_en,
    output p0_ready, p0_available, p0_q,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/sdram_p0_line_reader.sv
// SDRAM port-0 line reader: 8-word bursts into a 2-line buffer, unpacked to a
// 16-bit stream. Define SDRAM_RD_TIMEOUT_EN for the WAIT_DATA watchdog.
module sdram_p0_line_reader #(
  parameter int ADDR_WIDTH = 25,
  parameter int LEN_WIDTH  = 16
`ifdef SDRAM_RD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_complete,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
`ifdef SDRAM_RD_TIMEOUT_EN
  output logic                  timeout,
`endif
  sdram_p0_line_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_DATA, DRAIN
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] line_addr;
  logic [LEN_WIDTH:0]    span, lines_calc, lines_left;
  logic [LEN_WIDTH-1:0]  words_left;
  logic [2:0]            rd_idx;
  logic [127:0]          slot [2];
  logic [1:0]            full;
  logic                  head, tail;
  logic [15:0]           head_word, data_q;
  logic                  valid_q, last_q, done_q;
  logic                  accept, issue, line_wr;
  logic                  pop, line_free, final_xfer, abort;

  assign span = (LEN_WIDTH+1)'(start_addr[2:0])
              + (LEN_WIDTH+1)'(length)
              + (LEN_WIDTH+1)'(7);
  assign lines_calc = span >> 3;

  assign busy   = (state != IDLE);
  assign done   = done_q;
  assign accept = start && !busy;
  assign issue  = (state == ISSUE) && init_complete
               && bus.p0_ready && !(&full);
  assign line_wr = (state == WAIT_DATA) && bus.p0_available;

  // Output register only reloads when empty or being consumed
  assign head_word  = slot[head][{rd_idx, 4'b0000} +: 16];
  assign pop        = full[head] && (!valid_q || bus.out_ready);
  assign line_free  = pop && (rd_idx == 3'd7
                   || words_left == LEN_WIDTH'(1));
  assign final_xfer = valid_q && bus.out_ready && last_q;

  assign bus.p0_addr    = line_addr;
  assign bus.p0_rd_req  = issue;
  assign bus.p0_byte_en = 2'b11;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_last   = last_q;

`ifdef SDRAM_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_q;

  assign abort = (state == WAIT_DATA) && !bus.p0_available
              && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == WAIT_DATA && !abort)
        wait_cnt <= wait_cnt + TW'(1);
      else
        wait_cnt <= '0;
      if (abort)
        timeout_q <= 1'b1;
      else if (accept)
        timeout_q <= 1'b0;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept && length != '0)
          state_nx = ISSUE;
      ISSUE:
        if (issue)
          state_nx = WAIT_DATA;
      WAIT_DATA:
        if (abort)
          state_nx = IDLE;
        else if (line_wr)
          state_nx = (lines_left == (LEN_WIDTH+1)'(1))
                   ? DRAIN : ISSUE;
      DRAIN:
        if (final_xfer)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (line_wr)
      slot[tail] <= bus.p0_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_addr  <= '0;
      lines_left <= '0;
      words_left <= '0;
      rd_idx     <= '0;
      full       <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (accept) begin
        line_addr  <= {start_addr[ADDR_WIDTH-1:3], 3'b000};
        lines_left <= lines_calc;
        words_left <= length;
        rd_idx     <= start_addr[2:0];
      end
      if (issue)
        line_addr <= line_addr + ADDR_WIDTH'(8);
      if (line_wr)
        lines_left <= lines_left - (LEN_WIDTH+1)'(1);
      if (pop) begin
        words_left <= words_left - LEN_WIDTH'(1);
        rd_idx     <= line_free ? 3'd0 : rd_idx + 3'd1;
      end
      // Free before write so a same-cycle write into that slot wins
      if (line_free) begin
        full[head] <= 1'b0;
        head       <= ~head;
      end
      if (line_wr) begin
        full[tail] <= 1'b1;
        tail       <= ~tail;
      end
      if (abort) begin
        full <= '0;
        head <= 1'b0;
        tail <= 1'b0;
      end
      if (abort) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (pop) begin
        valid_q <= 1'b1;
        last_q  <= (words_left == LEN_WIDTH'(1));
        data_q  <= head_word;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      done_q <= (accept && length == '0)
             || (state == DRAIN && final_xfer)
             || abort;
    end
  end

endmodule

// File: doc/sdram_p0_line_reader.md
Name: sdram_p0_line_reader

Overview:
- Port-0 read initiator for the SDRAM controller: drives p0_addr / p0_rd_req and consumes p0_available / p0_q bursts.
- Fetches a contiguous run of 16-bit words from a start word address and length.
- Each 8-word burst (128-bit line) goes into a 2-line buffer, then is unpacked into a 16-bit valid/ready output stream with a last marker.
- Sits between the controller and video/DMA consumers.

Parameters:
- ADDR_WIDTH, 25, word address width; matches p0_addr.
- LEN_WIDTH, 16, width of the transfer length in words.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with SDRAM_RD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, same clock as the controller.
- reset_n  in  1  asynchronous, active-low reset.
- init_complete  in  1  controller init done; no request is issued while low.
- start  in  1  one-cycle command strobe; ignored while busy=1.
- start_addr  in  ADDR_WIDTH  first word address; any alignment.
- length  in  LEN_WIDTH  number of words; 0 is a legal no-op.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- p0_addr  out  ADDR_WIDTH  line-aligned request address (bits [2:0]=0).
- p0_rd_req  out  1  read request strobe.
- p0_byte_en  out  2  constant 2'b11.
- p0_ready  in  1  controller accepts a request this cycle.
- p0_available  in  1  p0_q valid this cycle (one-cycle pulse).
- p0_q  in  128  line data; word k is p0_q[16k+15:16k].
- out_data  out  16  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  consumer ready.
- out_last  out  1  qualifies the final word.

Behaviour:
Reset:
- All outputs 0: busy, done, p0_rd_req, p0_addr, out_valid, out_last, out_data. p0_byte_en=2'b11.
- Buffer emptied; FSM to IDLE. Async assert takes effect immediately, including mid-transfer; in-flight p0_available after reset is ignored.

Start:
- start && !busy latches start_addr, length, head offset = start_addr[2:0].
- lines = (start_addr[2:0] + length + 7) >> 3, computed at LEN_WIDTH+1 bits.
- length=0: done pulses the next cycle, busy stays 0, no request issued.

FSM IDLE -> ISSUE -> WAIT_DATA -> (ISSUE | DRAIN) -> IDLE:
- ISSUE: when init_complete && p0_ready && a buffer slot is free, drive p0_rd_req=1 for exactly one cycle with p0_addr = line address (first line = {start_addr[ADDR_WIDTH-1:3],3'b0}, then +8 per line, wrapping modulo 2^ADDR_WIDTH). Then go to WAIT_DATA. Only one request is outstanding at a time.
- WAIT_DATA: on p0_available, write p0_q into the tail slot and decrement remaining lines. If lines remain, go to ISSUE (the same cycle it becomes eligible); otherwise go to DRAIN.
- DRAIN: wait until the final word is accepted, then pulse done, clear busy, return to IDLE.
- p0_available in IDLE or ISSUE is ignored.

Output side (independent of FSM):
- out_valid=1 whenever the head line holds unsent words.
- out_data comes from a registered word mux: no combinational path from p0_q to out_data.
- First line starts at word offset start_addr[2:0]; last line stops after the final counted word.
- A word transfers on out_valid && out_ready. A line frees its slot after its last used word transfers.
- A line write and a line free in the same cycle are both honoured: the buffer never overflows, and the write lands in the freed slot if that slot was full.
- out_data/out_valid hold stable while out_ready=0.
- Latency: first out_valid appears 2 cycles after the first p0_available.

Optional Feature:
SDRAM_RD_TIMEOUT_EN:
- Defined: a cycle counter runs in WAIT_DATA. Reaching TIMEOUT_CYCLES with no p0_available triggers an abort:
  - buffer flushed, out_valid=0, done pulses, FSM returns to IDLE;
  - extra output port timeout (1 bit) sets sticky and clears on the next accepted start;
  - a late p0_available is ignored.
- Undefined: no counter, no timeout port; WAIT_DATA waits indefinitely.

Test Plan:
- Aligned: start_addr=0x322020, length=8, line preloaded 1234,5678,9ABC,DEF0,FEDC,BA98,7654,3210 -> one p0_rd_req with p0_addr=0x322020; 8 words out in that order; out_last on 3210; done one cycle after the last handshake.
- Unaligned span: start_addr=0x322026, length=4 -> requests 0x322020 then 0x322028; output 7654,3210 then words 0,1 of the second line; out_last on the 4th word.
- Backpressure: length=24 with out_ready=0 -> exactly 2 requests issued, third withheld; after out_ready=1 the third request issues once the head line drains; 24 words out, no loss or duplication.
- Gating: start while init_complete=0 or p0_ready=0 -> p0_rd_req stays 0 until both are 1; start while busy is ignored; length=0 -> done only, no request.
- Reset mid-transfer: reset_n=0 in WAIT_DATA -> all outputs 0 immediately; a subsequent p0_available produces no output; a new start after release works normally.
- SDRAM_RD_TIMEOUT_EN with TIMEOUT_CYCLES=16: withhold p0_available -> timeout=1 and done at cycle 16; next start clears timeout.
